// File: rtl/pipeline_pkg.sv
// Shared pipeline-stage definitions: stage buffer states, occupancy codes and
// the bubble payload used to blank empty or flushed slots.
package pipeline_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        BUSY  = 2'd1,
        FULL  = 2'd2
    } stage_state_e;

    localparam logic [1:0] OCC_EMPTY = 2'd0;
    localparam logic [1:0] OCC_ONE   = 2'd1;
    localparam logic [1:0] OCC_TWO   = 2'd2;

    // Wide enough for any stage payload; users slice to their own width.
    localparam logic [1023:0] BUBBLE = '0;

    function automatic logic [1:0] state_occupancy(input stage_state_e s);
        case (s)
            BUSY:    return OCC_ONE;
            FULL:    return OCC_TWO;
            default: return OCC_EMPTY;
        endcase
    endfunction

endpackage

// File: rtl/pipe_stage_buf_sat_counter.sv
// Saturating up-counter with a 0-3 increment per cycle; cleared only by reset.
module sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [1:0]       inc,
    output logic [WIDTH-1:0] count
);

    localparam int SUM_W = WIDTH + 2;

    logic [WIDTH-1:0] count_q, count_d;
    logic [SUM_W-1:0] sum;

    always_comb begin
        sum     = {2'b00, count_q} + SUM_W'(inc);
        count_d = sum[WIDTH-1:0];
        if (|sum[SUM_W-1:WIDTH]) begin
            count_d = '1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/pipe_stage_buf.sv
// Pipeline stage register with valid/ready handshake, two-entry skid buffer,
// synchronous flush and a saturating count of beats discarded by flush.
module pipe_stage_buf
    import pipeline_pkg::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int COUNT_WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   flush,
    input  logic                   in_valid,
    input  logic [DATA_WIDTH-1:0]  in_data,
    output logic                   in_ready,
    output logic                   out_valid,
    output logic [DATA_WIDTH-1:0]  out_data,
    input  logic                   out_ready,
    output logic [1:0]             occupancy,
    output logic [COUNT_WIDTH-1:0] drop_count
);

    localparam logic [DATA_WIDTH-1:0] ZERO_BEAT = BUBBLE[DATA_WIDTH-1:0];

    stage_state_e          state_q, state_d;
    logic [DATA_WIDTH-1:0] main_q, main_d;
    logic [DATA_WIDTH-1:0] skid_q, skid_d;
    logic                  in_ready_q, in_ready_d;
    logic                  in_fire, out_fire;
    logic [1:0]            occ;
    logic [1:0]            drop_inc;

    assign occ      = state_occupancy(state_q);
    assign in_fire  = in_valid & in_ready_q;
    assign out_fire = out_valid & out_ready;

    always_comb begin
        state_d  = state_q;
        main_d   = main_q;
        skid_d   = skid_q;
        drop_inc = 2'd0;

        unique case (state_q)
            EMPTY: begin
                if (in_fire) begin
                    main_d  = in_data;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (in_fire && out_fire) begin
                    main_d = in_data;
                end else if (in_fire) begin
                    skid_d  = in_data;
                    state_d = FULL;
                end else if (out_fire) begin
                    main_d  = ZERO_BEAT;
                    state_d = EMPTY;
                end
            end
            FULL: begin
                if (out_fire) begin
                    main_d  = skid_q;
                    skid_d  = ZERO_BEAT;
                    state_d = BUSY;
                end
            end
            default: begin
                main_d  = ZERO_BEAT;
                skid_d  = ZERO_BEAT;
                state_d = EMPTY;
            end
        endcase

        // Beats delivered this cycle survive the flush; everything else held
        // or accepted is lost. FULL never accepts, so the sum stays within 0-3.
        if (flush) begin
            state_d  = EMPTY;
            main_d   = ZERO_BEAT;
            skid_d   = ZERO_BEAT;
            drop_inc = occ - 2'(out_fire) + 2'(in_fire);
        end

        in_ready_d = (state_d != FULL);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= EMPTY;
            main_q     <= '0;
            skid_q     <= '0;
            in_ready_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            main_q     <= main_d;
            skid_q     <= skid_d;
            in_ready_q <= in_ready_d;
        end
    end

    sat_counter #(
        .WIDTH(COUNT_WIDTH)
    ) u_drop_cnt (
        .clk  (clk),
        .rst_n(rst_n),
        .inc  (drop_inc),
        .count(drop_count)
    );

    assign in_ready  = in_ready_q;
    assign out_valid = (state_q != EMPTY);
    assign out_data  = main_q;
    assign occupancy = occ;

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Randomised and directed checks of pipe_stage_buf against a queue-based model;
// a second instance with a 2-bit drop counter exercises saturation.
module tb_pipe_stage_buf;

    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          flush;
    logic          in_valid;
    logic [DW-1:0] in_data;
    logic          out_ready;

    logic          in_ready, out_valid;
    logic [DW-1:0] out_data;
    logic [1:0]    occupancy;
    logic [15:0]   drop_count;

    logic          s_in_ready, s_out_valid;
    logic [DW-1:0] s_out_data;
    logic [1:0]    s_occupancy;
    logic [1:0]    s_drop_count;

    pipe_stage_buf #(
        .DATA_WIDTH (DW),
        .COUNT_WIDTH(16)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .occupancy (occupancy),
        .drop_count(drop_count)
    );

    pipe_stage_buf #(
        .DATA_WIDTH (DW),
        .COUNT_WIDTH(2)
    ) dut_sat (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (s_in_ready),
        .out_valid (s_out_valid),
        .out_data  (s_out_data),
        .out_ready (out_ready),
        .occupancy (s_occupancy),
        .drop_count(s_drop_count)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: the stage is a FIFO of at most two beats.
    logic [DW-1:0] mq[$];
    bit            m_ready;
    longint        m_drops;

    function automatic longint sat(input longint v, input longint max);
        return (v > max) ? max : v;
    endfunction

    function automatic void model_reset();
        mq.delete();
        m_ready = 1'b1;
        m_drops = 0;
    endfunction

    function automatic void model_edge();
        bit in_f, out_f;
        in_f  = in_valid && m_ready;
        out_f = (mq.size() > 0) && out_ready;
        if (flush) begin
            m_drops += longint'(mq.size()) - longint'(out_f) + longint'(in_f);
            mq.delete();
            m_ready = 1'b1;
        end else begin
            if (out_f) void'(mq.pop_front());
            if (in_f) mq.push_back(in_data);
            m_ready = (mq.size() < 2);
        end
    endfunction

    task automatic check_all();
        logic [DW-1:0] exp_data;
        exp_data = (mq.size() > 0) ? mq[0] : '0;
        check_eq("out_valid", 64'(out_valid), 64'(mq.size() > 0));
        check_eq("out_data", 64'(out_data), 64'(exp_data));
        check_eq("in_ready", 64'(in_ready), 64'(m_ready));
        check_eq("occupancy", 64'(occupancy), 64'(mq.size()));
        check_eq("drop_count", 64'(drop_count), 64'(sat(m_drops, 65535)));
        check_eq("sat_out_data", 64'(s_out_data), 64'(exp_data));
        check_eq("sat_in_ready", 64'(s_in_ready), 64'(m_ready));
        check_eq("sat_drop_count", 64'(s_drop_count), 64'(sat(m_drops, 3)));
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_all();
    endtask

    task automatic send(input logic [DW-1:0] d);
        bit fired;
        int unsigned n;
        n        = 0;
        fired    = 1'b0;
        in_valid = 1'b1;
        in_data  = d;
        while (!fired && n < 20) begin
            fired = m_ready;
            step();
            n++;
        end
        check_eq("send_accepted", 64'(fired), 64'(1));
        in_valid = 1'b0;
    endtask

    task automatic idle(input int unsigned n);
        in_valid = 1'b0;
        for (int unsigned i = 0; i < n; i++) step();
    endtask

    initial begin
        longint base;

        rst_n     = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b1;
        in_data   = 32'hA5A5A5A5;
        out_ready = 1'b0;
        model_reset();
        #12;
        check_all();
        check_eq("rst_in_ready", 64'(in_ready), 64'(1));
        check_eq("rst_out_data", 64'(out_data), 64'(0));

        @(negedge clk);
        rst_n = 1'b1;
        send(32'hA5A5A5A5);
        check_eq("first_beat", 64'(out_data), 64'(32'hA5A5A5A5));
        check_eq("first_occ", 64'(occupancy), 64'(1));
        out_ready = 1'b1;
        idle(2);

        for (int unsigned i = 1; i <= 8; i++) begin
            send(DW'(i));
            check_eq("stream_ready", 64'(in_ready), 64'(1));
        end
        idle(2);

        // Stall behind the skid, then release in order
        out_ready = 1'b0;
        send(32'h10);
        send(32'h11);
        check_eq("skid_occ", 64'(occupancy), 64'(2));
        check_eq("skid_ready", 64'(in_ready), 64'(0));
        in_valid = 1'b1;
        in_data  = 32'h12;
        step();
        step();
        out_ready = 1'b1;
        send(32'h12);
        idle(4);

        // Flush a full stage
        out_ready = 1'b0;
        send(32'h20);
        send(32'h21);
        base  = m_drops;
        flush = 1'b1;
        step();
        flush = 1'b0;
        check_eq("flush_full_valid", 64'(out_valid), 64'(0));
        check_eq("flush_full_drops", 64'(drop_count), 64'(base + 2));

        // Flush while delivering 0x30 and accepting 0x31
        send(32'h30);
        base      = m_drops;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = 32'h31;
        flush     = 1'b1;
        step();
        flush    = 1'b0;
        in_valid = 1'b0;
        check_eq("flush_busy_drops", 64'(drop_count), 64'(base + 1));
        check_eq("flush_busy_occ", 64'(occupancy), 64'(0));

        // Asynchronous reset mid-transfer, then saturation of the 2-bit counter
        out_ready = 1'b0;
        send(32'h40);
        send(32'h41);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check_all();
        @(negedge clk);
        rst_n = 1'b1;
        for (int unsigned k = 0; k < 3; k++) begin
            send(32'h50 + DW'(k));
            send(32'h60 + DW'(k));
            flush = 1'b1;
            step();
            flush = 1'b0;
            check_eq("sat_step", 64'(s_drop_count), 64'((k == 0) ? 2 : 3));
        end

        for (int unsigned c = 0; c < 3000; c++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            in_data   = $urandom;
            out_ready = ($urandom_range(0, 3) != 0);
            flush     = ($urandom_range(0, 15) == 0);
            step();
        end
        flush = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
